button_event_capture: RTL and testbench



---
 rtl/okbtn_pkg.sv | 17 +
 rtl/debounce_cell.sv | 61 ++++++
 rtl/button_event_capture.sv | 88 ++++++++
 tb/tb_button_event_capture.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/okbtn_pkg.sv
// Shared constants and status-word bit placement for the button event capture block.
package okbtn_pkg;

    localparam int         STATUS_W                = 16;
    localparam logic [7:0] COUNT_MAX               = 8'd255;
    localparam int         DEFAULT_DEBOUNCE_CYCLES = 48000;

    // Debounced levels occupy the low bits of the status word, pending flags sit right above them.
    function automatic logic [3:0] level_bit(input int idx);
        return 4'(idx);
    endfunction

    function automatic logic [3:0] pending_bit(input int idx, input int nButtons);
        return 4'(nButtons + idx);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: two-flop synchronizer, stability counter, debounced level and a one-cycle rise pulse.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_button_raw,
    output logic o_level,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;
    logic             w_pressed;

    // Raw pins are active-low, so idle flops sit at 1 and the inverted output reads "not pressed".
    assign w_pressed = ~r_sync2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_button_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Any return to the accepted level restarts the stability count from zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_pressed == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_level <= w_pressed;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_level & ~r_level_d;

endmodule

// File: rtl/button_event_capture.sv
// Debounced button levels, sticky press flags and saturating press counters for host WireOut readback.
module button_event_capture
    import okbtn_pkg::*;
#(
    parameter int N_BUTTONS       = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic                   ti_clk,
    input  logic                   rst_n,
    input  logic [N_BUTTONS-1:0]   button_raw,
    input  logic                   clr_in,
    output logic [N_BUTTONS-1:0]   level,
    output logic [N_BUTTONS-1:0]   pending,
    output logic [8*N_BUTTONS-1:0] press_count,
    output logic [STATUS_W-1:0]    status_word
);

    logic [N_BUTTONS-1:0] w_level;
    logic [N_BUTTONS-1:0] w_rise;
    logic [N_BUTTONS-1:0] r_pending;
    logic [7:0]           r_count [N_BUTTONS];
    logic                 r_clr_d;
    logic                 w_clr;
    logic [STATUS_W-1:0]  w_status;

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .i_clk       (ti_clk),
            .i_rst_n     (rst_n),
            .i_button_raw(button_raw[g]),
            .o_level     (w_level[g]),
            .o_rise      (w_rise[g])
        );
        assign press_count[8*g +: 8] = r_count[g];
    end

    // A WireIn bit left high must clear only once, so act on its rising edge.
    always_ff @(posedge ti_clk) begin
        if (!rst_n) begin
            r_clr_d <= 1'b0;
        end else begin
            r_clr_d <= clr_in;
        end
    end

    assign w_clr = clr_in & ~r_clr_d;

    // A press landing with a clear counts as the first press after that clear.
    always_ff @(posedge ti_clk) begin
        if (!rst_n) begin
            r_pending <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                r_count[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                if (w_rise[i]) begin
                    r_pending[i] <= 1'b1;
                    if (w_clr) begin
                        r_count[i] <= 8'd1;
                    end else if (r_count[i] != COUNT_MAX) begin
                        r_count[i] <= r_count[i] + 8'd1;
                    end
                end else if (w_clr) begin
                    r_pending[i] <= 1'b0;
                    r_count[i]   <= 8'd0;
                end
            end
        end
    end

    always_comb begin
        w_status = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            w_status[level_bit(i)]              = w_level[i];
            w_status[pending_bit(i, N_BUTTONS)] = r_pending[i];
        end
    end

    assign level       = w_level;
    assign pending     = r_pending;
    assign status_word = w_status;

endmodule

// File: tb/tb_button_event_capture.sv
// Directed self-checking bench for button_event_capture with a short debounce window.
module tb_button_event_capture;

    localparam int N  = 2;
    localparam int DB = 4;

    logic            ti_clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    button_raw;
    logic            clr_in;
    logic [N-1:0]    level;
    logic [N-1:0]    pending;
    logic [8*N-1:0]  press_count;
    logic [15:0]     status_word;

    int compareCount  = 0;
    int mismatchCount = 0;

    button_event_capture #(
        .N_BUTTONS      (N),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (16)
    ) dut (
        .ti_clk     (ti_clk),
        .rst_n      (rst_n),
        .button_raw (button_raw),
        .clr_in     (clr_in),
        .level      (level),
        .pending    (pending),
        .press_count(press_count),
        .status_word(status_word)
    );

    always #5 ti_clk = ~ti_clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge ti_clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        button_raw = 2'b11;
        clr_in     = 1'b0;
        applyStimulus(2);
        checkOutput("rst_level",   16'(level), 16'h0);
        checkOutput("rst_pending", 16'(pending), 16'h0);
        checkOutput("rst_count",   press_count, 16'h0000);
        checkOutput("rst_status",  status_word, 16'h0000);

        rst_n = 1'b1;
        applyStimulus(20);
        checkOutput("idle_level",  16'(level), 16'h0);
        checkOutput("idle_count",  press_count, 16'h0000);
        checkOutput("idle_status", status_word, 16'h0000);

        // Button 0 press: level appears on the 6th edge, bookkeeping one edge later.
        button_raw[0] = 1'b0;
        applyStimulus(5);
        checkOutput("b0_level_early", 16'(level), 16'h0);
        applyStimulus(1);
        checkOutput("b0_level_on",    16'(level), 16'h1);
        checkOutput("b0_pending_pre", 16'(pending), 16'h0);
        applyStimulus(1);
        checkOutput("b0_pending",     16'(pending), 16'h1);
        checkOutput("b0_count",       press_count, 16'h0001);
        checkOutput("b0_status",      status_word, 16'h0005);
        button_raw[0] = 1'b1;
        applyStimulus(8);
        checkOutput("b0_release_status", status_word, 16'h0004);
        checkOutput("b0_release_count",  press_count, 16'h0001);

        // Button 1 bouncing every 2 cycles never reaches the 4-cycle window.
        for (int i = 0; i < 8; i++) begin
            button_raw[1] = 1'b0;
            applyStimulus(2);
            button_raw[1] = 1'b1;
            applyStimulus(2);
        end
        applyStimulus(10);
        checkOutput("bounce_level", 16'(level), 16'h0);
        checkOutput("bounce_count", {8'h00, press_count[15:8]}, 16'h0000);

        for (int i = 0; i < 300; i++) begin
            button_raw[0] = 1'b0;
            applyStimulus(8);
            button_raw[0] = 1'b1;
            applyStimulus(8);
        end
        checkOutput("sat_count", {8'h00, press_count[7:0]}, 16'h00FF);

        clr_in = 1'b1;
        applyStimulus(1);
        checkOutput("clr_count",   {8'h00, press_count[7:0]}, 16'h0000);
        checkOutput("clr_pending", 16'(pending), 16'h0);
        applyStimulus(9);
        checkOutput("clr_held_count", {8'h00, press_count[7:0]}, 16'h0000);
        clr_in = 1'b0;
        applyStimulus(2);
        button_raw[0] = 1'b0;
        applyStimulus(7);
        checkOutput("post_clr_count",   {8'h00, press_count[7:0]}, 16'h0001);
        checkOutput("post_clr_pending", 16'(pending), 16'h1);
        button_raw[0] = 1'b1;
        applyStimulus(8);

        button_raw[1] = 1'b0;
        applyStimulus(8);
        button_raw[1] = 1'b1;
        applyStimulus(8);
        checkOutput("b1_first_count", {8'h00, press_count[15:8]}, 16'h0001);

        // Clear edge aligned with the button 1 rise pulse.
        button_raw[1] = 1'b0;
        applyStimulus(6);
        clr_in = 1'b1;
        applyStimulus(1);
        checkOutput("race_pending", 16'(pending), 16'h2);
        checkOutput("race_count",   press_count, 16'h0100);
        clr_in = 1'b0;
        button_raw = 2'b11;
        applyStimulus(8);

        // Reset in the middle of a debounce discards the partial count.
        button_raw[0] = 1'b0;
        applyStimulus(4);
        rst_n = 1'b0;
        applyStimulus(1);
        checkOutput("midrst_level",   16'(level), 16'h0);
        checkOutput("midrst_pending", 16'(pending), 16'h0);
        checkOutput("midrst_count",   press_count, 16'h0000);
        checkOutput("midrst_status",  status_word, 16'h0000);
        rst_n = 1'b1;
        applyStimulus(5);
        checkOutput("midrst_level_early", 16'(level), 16'h0);
        applyStimulus(1);
        checkOutput("midrst_level_on", 16'(level), 16'h1);
        applyStimulus(1);
        checkOutput("midrst_count_after", press_count, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
